// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared states, opcodes and datapath select encodings for the multi-cycle controller
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps opcode/funct fields to an ALU operation and flags unsupported funct3 values
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o,
    output logic       illegal_funct_o
);

    always_comb begin
        alu_control_o   = ALU_ADD;
        illegal_funct_o = 1'b0;
        case (funct3_i)
            // addi never subtracts, so bit 30 only matters for register-register ops
            3'b000:  alu_control_o = (op_i == OP_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_control_o = ALU_SLT;
            3'b110:  alu_control_o = ALU_OR;
            3'b111:  alu_control_o = ALU_AND;
            default: illegal_funct_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multi-cycle sequencing FSM with memory stall and retire counter
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       imm_src,
    output logic [2:0]       alu_control,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;

    logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c;
    logic       retire_c;
    logic [2:0] dec_alu_control;
    logic       dec_illegal_funct;

    alu_decoder u_alu_decoder (
        .op_i            (op),
        .funct3_i        (funct3),
        .funct7b5_i      (funct7b5),
        .alu_control_o   (dec_alu_control),
        .illegal_funct_o (dec_illegal_funct)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_write_c  = 1'b0;
        adr_src     = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RD2;
        alu_control = ALU_ADD;
        retire_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut captures PC-relative target here for a following beq
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                result_src  = RES_DATA;
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                // request held steady until memory accepts it
                adr_src     = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready) begin
                    retire_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXECUTER, S_EXECUTEI: begin
                alu_src_a   = SRCA_RD1;
                alu_src_b   = (state_q == S_EXECUTEI) ? SRCB_IMM : SRCB_RD2;
                alu_control = dec_alu_control;
                state_d     = dec_illegal_funct ? S_ERROR : S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a   = SRCA_RD1;
                alu_control = ALU_SUB;
                pc_write_c  = zero;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write_c = 1'b1;
                state_d    = S_ALUWB;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase
    end

    assign retired_d = retire_c ? retired_q + CNT_W'(1) : retired_q;
    assign illegal_d = illegal_q | (state_d == S_ERROR);

    // no write may leak out while reset is held, whatever state the register still shows
    assign pc_write  = rst_n & pc_write_c;
    assign mem_write = rst_n & mem_write_c;
    assign ir_write  = rst_n & ir_write_c;
    assign reg_write = rst_n & reg_write_c;

    assign imm_src = imm_src_of(op);
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized instruction-stream bench against a phase-table reference model
module tb_multicycle_controller;

    localparam int CW = 4;

    localparam logic [6:0] M_LW  = 7'b0000011;
    localparam logic [6:0] M_SW  = 7'b0100011;
    localparam logic [6:0] M_R   = 7'b0110011;
    localparam logic [6:0] M_I   = 7'b0010011;
    localparam logic [6:0] M_BEQ = 7'b1100011;
    localparam logic [6:0] M_JAL = 7'b1101111;

    localparam int P_FETCHW = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRDW = 4,
                   P_MEMRD = 5, P_MEMWB = 6, P_MEMWRW = 7, P_MEMWR = 8, P_EXEC = 9,
                   P_ALUWB = 10, P_BEQ = 11, P_JAL = 12, P_ERROR = 13;

    localparam logic [16:0] ALL    = 17'h1FFFF;
    localparam logic [16:0] NO_ALU = 17'h1FFF1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    op = 7'd0;
    logic [2:0]    funct3 = 3'd0;
    logic          funct7b5 = 1'b0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]    result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]    alu_control;
    logic [CW-1:0] retired;

    multicycle_controller #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .illegal     (illegal),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mr;
        logic        z;
        logic [16:0] exp;
        logic [16:0] mask;
        int          ph;
    } ent_t;

    ent_t        q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned model_ret = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom & 32'd1);
    endfunction

    function automatic string ph_name(input int ph);
        case (ph)
            P_FETCHW: return "fetch_wait";
            P_FETCH:  return "fetch";
            P_DECODE: return "decode";
            P_MEMADR: return "memadr";
            P_MEMRDW: return "memread_wait";
            P_MEMRD:  return "memread";
            P_MEMWB:  return "memwb";
            P_MEMWRW: return "memwrite_wait";
            P_MEMWR:  return "memwrite";
            P_EXEC:   return "execute";
            P_ALUWB:  return "aluwb";
            P_BEQ:    return "beq";
            P_JAL:    return "jal";
            default:  return "error";
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        if (o == M_SW)  return 2'b01;
        if (o == M_BEQ) return 2'b10;
        if (o == M_JAL) return 2'b11;
        return 2'b00;
    endfunction

    // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, src_a, src_b, imm_src, alu, illegal}
    function automatic logic [16:0] vec(input logic pcw, input logic adr, input logic mw,
                                        input logic irw, input logic rw, input logic [1:0] rs,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [1:0] im, input logic [2:0] alu, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, im, alu, ill};
    endfunction

    task automatic push(input int ph, input logic mr, input logic z,
                        input logic [16:0] e, input logic [16:0] m);
        ent_t x;
        x.mr = mr; x.z = z; x.exp = e; x.mask = m; x.ph = ph;
        q.push_back(x);
    endtask

    // Expands one instruction into its per-cycle expected outputs, stalls included.
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input int fw, input int mw, input int zsel,
                         output logic ret, output logic err);
        logic [1:0] im;
        logic [2:0] alu;
        logic       legal;
        logic       zb;
        im  = exp_imm(o);
        ret = 1'b0;
        err = 1'b0;
        q.delete();
        repeat (fw) push(P_FETCHW, 1'b0, rbit(), vec(0,0,0,0,0,2'b10,2'b00,2'b10,im,3'b000,0), ALL);
        push(P_FETCH, 1'b1, rbit(), vec(1,0,0,1,0,2'b10,2'b00,2'b10,im,3'b000,0), ALL);
        push(P_DECODE, rbit(), rbit(), vec(0,0,0,0,0,2'b00,2'b01,2'b01,im,3'b000,0), ALL);
        if (o == M_LW) begin
            push(P_MEMADR, rbit(), rbit(), vec(0,0,0,0,0,2'b00,2'b10,2'b01,im,3'b000,0), ALL);
            repeat (mw) push(P_MEMRDW, 1'b0, rbit(), vec(0,1,0,0,0,2'b00,2'b00,2'b00,im,3'b000,0), ALL);
            push(P_MEMRD, 1'b1, rbit(), vec(0,1,0,0,0,2'b00,2'b00,2'b00,im,3'b000,0), ALL);
            push(P_MEMWB, rbit(), rbit(), vec(0,0,0,0,1,2'b01,2'b00,2'b00,im,3'b000,0), ALL);
            ret = 1'b1;
        end else if (o == M_SW) begin
            push(P_MEMADR, rbit(), rbit(), vec(0,0,0,0,0,2'b00,2'b10,2'b01,im,3'b000,0), ALL);
            repeat (mw) push(P_MEMWRW, 1'b0, rbit(), vec(0,1,1,0,0,2'b00,2'b00,2'b00,im,3'b000,0), ALL);
            push(P_MEMWR, 1'b1, rbit(), vec(0,1,1,0,0,2'b00,2'b00,2'b00,im,3'b000,0), ALL);
            ret = 1'b1;
        end else if (o == M_R || o == M_I) begin
            legal = 1'b1;
            alu   = 3'b000;
            case (f3)
                3'b000:  alu = (o == M_R && f7) ? 3'b001 : 3'b000;
                3'b010:  alu = 3'b101;
                3'b110:  alu = 3'b011;
                3'b111:  alu = 3'b010;
                default: legal = 1'b0;
            endcase
            push(P_EXEC, rbit(), rbit(),
                 vec(0,0,0,0,0,2'b00,2'b10,(o == M_R) ? 2'b00 : 2'b01,im,alu,0),
                 legal ? ALL : NO_ALU);
            if (legal) begin
                push(P_ALUWB, rbit(), rbit(), vec(0,0,0,0,1,2'b00,2'b00,2'b00,im,3'b000,0), ALL);
                ret = 1'b1;
            end else begin
                err = 1'b1;
            end
        end else if (o == M_BEQ) begin
            zb = (zsel < 0) ? rbit() : 1'(zsel);
            push(P_BEQ, rbit(), zb, vec(zb,0,0,0,0,2'b00,2'b10,2'b00,im,3'b001,0), ALL);
            ret = 1'b1;
        end else if (o == M_JAL) begin
            push(P_JAL, rbit(), rbit(), vec(1,0,0,0,0,2'b00,2'b01,2'b10,im,3'b000,0), ALL);
            push(P_ALUWB, rbit(), rbit(), vec(0,0,0,0,1,2'b00,2'b00,2'b00,im,3'b000,0), ALL);
            ret = 1'b1;
        end else begin
            err = 1'b1;
        end
        if (err) begin
            repeat (10) push(P_ERROR, rbit(), rbit(), vec(0,0,0,0,0,2'b00,2'b00,2'b00,im,3'b000,1), ALL);
        end
    endtask

    task automatic do_reset(input int n, input logic mr_one);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            mem_ready = mr_one ? 1'b1 : rbit();
            @(negedge clk);
            check("rst_enables", {28'd0, pc_write, ir_write, reg_write, mem_write}, 32'd0);
            if (i > 0) begin
                check("rst_retired", 32'(retired), 32'd0);
                check("rst_illegal", {31'd0, illegal}, 32'd0);
            end
        end
        model_ret = 0;
    endtask

    task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input int fw, input int mw, input int zsel, input int cut);
        logic        ret, err;
        int          n;
        logic [16:0] act;
        build(o, f3, f7, fw, mw, zsel, ret, err);
        n = (cut > 0 && cut < q.size()) ? cut : q.size();
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            mem_ready = q[i].mr;
            zero = q[i].z;
            @(negedge clk);
            act = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                   alu_src_a, alu_src_b, imm_src, alu_control, illegal};
            check(ph_name(q[i].ph), 32'(act & q[i].mask), 32'(q[i].exp & q[i].mask));
            if (i == 0) check("retired", 32'(retired), 32'(model_ret));
        end
        if (n < q.size() || err) begin
            do_reset(1 + int'($urandom % 3), 1'b0);
        end else if (ret) begin
            model_ret = (model_ret + 1) % (1 << CW);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ro;
        logic [2:0] rf3;
        int         sel, cut;
        logic [6:0] legal_ops [6];
        logic [2:0] legal_f3 [4];
        legal_ops = '{M_LW, M_SW, M_R, M_I, M_BEQ, M_JAL};
        legal_f3  = '{3'b000, 3'b010, 3'b110, 3'b111};

        do_reset(2, 1'b1);

        do_instr(M_R,   3'b000, 1'b0, 0, 0, -1, 0);
        do_instr(M_R,   3'b000, 1'b1, 0, 0, -1, 0);
        do_instr(M_LW,  3'b010, 1'b0, 0, 2, -1, 0);
        do_instr(M_BEQ, 3'b000, 1'b0, 0, 0,  1, 0);
        do_instr(M_BEQ, 3'b000, 1'b0, 0, 0,  0, 0);
        do_instr(M_JAL, 3'b000, 1'b0, 0, 0, -1, 0);
        do_instr(M_SW,  3'b010, 1'b0, 1, 3, -1, 0);
        do_instr(M_I,   3'b111, 1'b1, 0, 0, -1, 0);
        do_instr(M_R,   3'b101, 1'b0, 0, 0, -1, 0);
        do_instr(7'b0110111, 3'b000, 1'b0, 0, 0, -1, 0);
        do_instr(M_LW,  3'b010, 1'b0, 0, 4, -1, 5);

        for (int k = 0; k < 300; k++) begin
            sel = int'($urandom % 100);
            ro  = (sel < 4) ? 7'($urandom) : legal_ops[$urandom % 6];
            rf3 = (($urandom % 10) == 0) ? 3'($urandom) : legal_f3[$urandom % 4];
            cut = (($urandom % 100) < 6) ? 1 + int'($urandom % 8) : 0;
            do_instr(ro, rf3, rbit(), int'($urandom % 3), int'($urandom % 3), -1, cut);
        end

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("final_retired", 32'(retired), 32'(model_ret));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing control FSM for the multi-cycle RV32I datapath variant, which shares one memory port and one ALU across the cycles of each instruction. It decodes the latched instruction fields and steps the datapath through fetch, decode, execute, memory and write-back, one phase per cycle. It stalls on a memory ready handshake and counts retired instructions. It sits beside the datapath, and it drives every mux select, write enable and ALU operation the datapath consumes.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- op  in  7  opcode, Instr[6:0], from the instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- pc_write  out  1  PC register load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = Result
- mem_write  out  1  memory write request
- ir_write  out  1  instruction/OldPC register load enable
- reg_write  out  1  register file write enable
- result_src  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1
- alu_src_b  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4
- imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  3  ALU operation: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- illegal  out  1  sticky flag for an unsupported instruction
- retired  out  CNT_W  count of retired instructions

## Operation
- Supported opcodes:
  - lw 0000011
  - sw 0100011
  - R-type 0110011
  - I-type ALU 0010011
  - beq 1100011
  - jal 1101111
- imm_src is decoded combinationally from op in every state: lw/I → 00, sw → 01, beq → 10, jal → 11, others → 00.
- ALU decode for EXECUTER and EXECUTEI:
  - funct3 000 → add; sub only when R-type and funct7b5 = 1.
  - 010 → slt (101).
  - 110 → or (011).
  - 111 → and (010).
  - Any other funct3 is illegal.
- Outputs not listed for a state are 0.

States (Moore outputs):
- FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, add, result_src 10. ir_write = pc_write = mem_ready. Exits to DECODE when mem_ready; otherwise holds.
- DECODE: alu_src_a 01, alu_src_b 01, add (forms the branch target in ALUOut). Next state:
  - lw/sw → MEMADR
  - R → EXECUTER
  - I → EXECUTEI
  - beq → BEQ
  - jal → JAL
  - any other op → ERROR
- MEMADR: alu_src_a 10, alu_src_b 01, add. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src 1, result_src 00. Exits to MEMWB when mem_ready; otherwise holds.
- MEMWB: result_src 01, reg_write 1. Goes to FETCH.
- MEMWRITE: adr_src 1, result_src 00, mem_write 1. Holds until mem_ready, then goes to FETCH.
- EXECUTER / EXECUTEI: alu_src_a 10, alu_src_b 00 (R) or 01 (I), decoded op. Goes to ALUWB, or to ERROR on an illegal funct3.
- ALUWB: result_src 00, reg_write 1. Goes to FETCH.
- BEQ: alu_src_a 10, alu_src_b 00, sub, result_src 00, pc_write = zero. Goes to FETCH.
- JAL: alu_src_a 01, alu_src_b 10, add, result_src 00, pc_write 1. Goes to ALUWB.
- ERROR: all enables 0, illegal = 1. Stays in ERROR until reset.

Retired-instruction counter:
- Increments by 1 on each transition into FETCH from MEMWB, ALUWB, BEQ, or MEMWRITE (when mem_ready).
- Wraps modulo 2^CNT_W.

## Timing
- Reset: on any edge with rst_n = 0, state ← FETCH, retired ← 0, illegal ← 0. While rst_n = 0, all write enables are forced to 0 combinationally. Reset overrides every in-flight state, including memory waits.
- Latency with mem_ready held at 1:
  - beq: 3 cycles
  - R, I, sw, jal: 4 cycles
  - lw: 5 cycles
- Each wait cycle in FETCH, MEMREAD or MEMWRITE adds 1 cycle.
- mem_write and adr_src stay stable throughout a MEMWRITE wait. The memory commits the write only on the cycle where mem_ready = 1.
- Outputs depend on state only, except ir_write/pc_write in FETCH (gated by mem_ready) and pc_write in BEQ (gated by zero).

## Structure
- Package riscv_ctrl_pkg holds:
  - the state enum
  - opcode constants
  - alu_control codes
  - result_src, alu_src_a, alu_src_b and imm_src encodings
- Sub-module alu_decoder: combinational mapping from (op, funct3, funct7b5) to (alu_control, illegal_funct). Instantiated once.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles, with mem_ready = 1 → all enables 0 and retired = 0. After release, the first cycle is FETCH with pc_write = 1 and ir_write = 1.
- add then sub: R-type funct3 000 with funct7b5 0, then with funct7b5 1 → alu_control 000 then 001 in EXECUTER, reg_write in ALUWB; 4 cycles each; retired = 2.
- lw with memory stall: mem_ready low for 2 cycles in MEMREAD → lw completes in 7 cycles total, MEMWB asserts reg_write with result_src 01.
- beq: zero = 1 → pc_write = 1 in BEQ. zero = 0 → pc_write = 0. Both take 3 cycles.
- jal: → pc_write with alu_src_a 01 / alu_src_b 10 in JAL, then reg_write in ALUWB; 4 cycles.
- Illegal instruction: op 0110111 → ERROR after DECODE, illegal = 1, all enables 0 for 10 cycles. Asserting rst_n = 0 clears illegal and returns to FETCH.
